rborrow_4bit_seq: RTL



---
 rtl/rb_pkg.sv | 15 +
 rtl/fs_1bit.sv | 14 +
 rtl/rborrow_4bit_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/rb_pkg.sv
// Shared definitions for the bit-serial 4-bit subtractor.
// Holds the operand width, FSM state encoding and counter terminal value.
package rb_pkg;

   localparam int RB_W = 4;

   typedef enum logic [1:0] {
      RB_IDLE = 2'd0,
      RB_RUN  = 2'd1,
      RB_DONE = 2'd2
   } rb_state_t;

   localparam logic [1:0] RB_LAST = 2'd3;

endpackage

// File: rtl/fs_1bit.sv
// 1-bit combinational full subtractor: d = a - b - bin.
// Ports: a, b, bin (in); d difference, bout borrow-out (out).
module fs_1bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/rborrow_4bit_seq.sv
// Bit-serial 4-bit subtractor, d = a - b - bin, one bit per clock.
// Ports: clk, rst, start, a, b, bin in; d, bout, busy, done out.
module rborrow_4bit_seq
   import rb_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [RB_W-1:0] a,
   input  logic [RB_W-1:0] b,
   input  logic            bin,
   output logic [RB_W-1:0] d,
   output logic            bout,
   output logic            busy,
   output logic            done
);

   rb_state_t       state;
   rb_state_t       nstate;
   logic [RB_W-1:0] sa;
   logic [RB_W-1:0] sb;
   logic [RB_W-1:0] sr;
   logic            br;
   logic [1:0]      cnt;
   logic            fdiff;
   logic            fbor;

   fs_1bit u_fs (
      .a    (sa[0]),
      .b    (sb[0]),
      .bin  (br),
      .d    (fdiff),
      .bout (fbor)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RB_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         RB_IDLE: if (start) nstate = RB_RUN;
         RB_RUN:  if (cnt == RB_LAST) nstate = RB_DONE;
         RB_DONE: nstate = RB_IDLE;
         default: nstate = RB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa   <= '0;
         sb   <= '0;
         sr   <= '0;
         br   <= 1'b0;
         cnt  <= 2'd0;
         d    <= '0;
         bout <= 1'b0;
      end else begin
         unique case (state)
            RB_IDLE: begin
               if (start) begin
                  sa  <= a;
                  sb  <= b;
                  br  <= bin;
                  cnt <= 2'd0;
               end
            end
            RB_RUN: begin
               sa  <= {1'b0, sa[RB_W-1:1]};
               sb  <= {1'b0, sb[RB_W-1:1]};
               sr  <= {fdiff, sr[RB_W-1:1]};
               br  <= fbor;
               cnt <= cnt + 2'd1;
               // outputs take the finished word only on the last bit
               if (cnt == RB_LAST) begin
                  d    <= {fdiff, sr[RB_W-1:1]};
                  bout <= fbor;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != RB_IDLE);
   assign done = (state == RB_DONE);

endmodule
